// File: rtl/sift_pkg.sv
// Shared types and keypoint word layout for the keypoint writer.
// Optional build macro: KEYPOINT_POLARITY_EN adds a polarity bit to each keypoint word.
package sift_pkg;

  typedef enum logic [1:0] {
    KP_IDLE    = 2'd0,
    KP_COLLECT = 2'd1,
    KP_DRAIN   = 2'd2,
    KP_DONE    = 2'd3
  } kp_state_t;

  // Reference image geometry (64x64)
  localparam int unsigned KP_DIMENSION = 64;
  localparam int unsigned KP_COORD_W   = $clog2(KP_DIMENSION);

`ifdef KEYPOINT_POLARITY_EN
  localparam int unsigned KP_POL_W   = 1;
  localparam int unsigned KP_WIDTH   = 2 + 2 * KP_COORD_W;
  localparam int unsigned KP_POL_BIT = 2 * KP_COORD_W;
`else
  localparam int unsigned KP_POL_W   = 0;
  localparam int unsigned KP_WIDTH   = 1 + 2 * KP_COORD_W;
`endif

  // Field offsets inside the keypoint word: {layer, [polarity], x, y}
  localparam int unsigned KP_Y_LSB     = 0;
  localparam int unsigned KP_X_LSB     = KP_COORD_W;
  localparam int unsigned KP_LAYER_BIT = KP_WIDTH - 1;

  // Same layout, for an arbitrary coordinate width
  function automatic int unsigned kp_width(input int unsigned coord_w);
    return 1 + KP_POL_W + 2 * coord_w;
  endfunction

  function automatic int unsigned kp_x_lsb(input int unsigned coord_w);
    return coord_w;
  endfunction

  function automatic int unsigned kp_pol_bit(input int unsigned coord_w);
    return 2 * coord_w;
  endfunction

  function automatic int unsigned kp_layer_bit(input int unsigned coord_w);
    return 2 * coord_w + KP_POL_W;
  endfunction

endpackage

// File: rtl/kp_queue.sv
// Pending-keypoint FIFO: two writes and one read per cycle, DEPTH a power of two.
// Free count reflects start-of-cycle occupancy; a same-cycle read does not make room.
module kp_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 13,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          wr0_en_i,
  input  logic [W-1:0]  wr0_data_i,
  input  logic          wr1_en_i,
  input  logic [W-1:0]  wr1_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] free_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wr1_ptr_c;

  assign wr1_ptr_c = wr_ptr_q + PW'(wr0_en_i);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign free_o    = CW'(DEPTH) - cnt_q;

  // Storage; layer-1 entry lands ahead of the layer-2 entry
  always_ff @(posedge clk) begin
    if (wr0_en_i) mem_q[wr_ptr_q]  <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1_ptr_c] <= wr1_data_i;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
      rd_ptr_q <= rd_ptr_q + PW'(rd_en_i);
      cnt_q    <= cnt_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
    end
  end

endmodule

// File: rtl/keypoint_writer.sv
// Collects extrema from the two-layer extrema checker, queues them and writes
// them to the keypoint BRAM, one word per cycle, tracking count and overflow.
// Optional build macro: KEYPOINT_POLARITY_EN (adds the polarity bit to kp_data).
module keypoint_writer
  import sift_pkg::*;
#(
  parameter int unsigned DIMENSION     = 64,
  parameter int unsigned MAX_KEYPOINTS = 1024,
  parameter int unsigned QUEUE_DEPTH   = 4,
  localparam int unsigned COORD_W      = $clog2(DIMENSION),
  localparam int unsigned AW           = $clog2(MAX_KEYPOINTS),
  localparam int unsigned CNT_W        = AW + 1,
  localparam int unsigned KP_W         = kp_width(COORD_W),
  localparam int unsigned FREE_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               enable,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               first_is_extremum,
  input  logic               second_is_extremum,
  input  logic               first_is_max,
  input  logic               second_is_max,
  input  logic               done_checking,
  output logic [AW-1:0]      kp_addr,
  output logic [KP_W-1:0]    kp_data,
  output logic               kp_we,
  output logic [CNT_W-1:0]   kp_count,
  output logic               overflow,
  output logic               done
);

  localparam int unsigned X_LSB     = kp_x_lsb(COORD_W);
  localparam int unsigned LAYER_BIT = kp_layer_bit(COORD_W);

  kp_state_t          state_q, state_d;
  logic [AW-1:0]      kp_addr_q, kp_addr_d;
  logic [KP_W-1:0]    kp_data_q, kp_data_d;
  logic               kp_we_q, kp_we_d;
  logic [CNT_W-1:0]   kp_count_q, kp_count_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic               q_clear_c;
  logic               q_wr0_c;
  logic               q_wr1_c;
  logic               q_rd_c;
  logic [KP_W-1:0]    q_head;
  logic               q_full;
  logic               q_empty;
  logic [FREE_W-1:0]  q_free;
  logic [KP_W-1:0]    l1_word_c;
  logic [KP_W-1:0]    l2_word_c;

  // Pack the current coordinate into a keypoint word for each layer
  always_comb begin
    l1_word_c = '0;
    l1_word_c[0 +: COORD_W]     = y;
    l1_word_c[X_LSB +: COORD_W] = x;
    l1_word_c[LAYER_BIT]        = 1'b0;
    l2_word_c = l1_word_c;
    l2_word_c[LAYER_BIT]        = 1'b1;
`ifdef KEYPOINT_POLARITY_EN
    l1_word_c[kp_pol_bit(COORD_W)] = first_is_max;
    l2_word_c[kp_pol_bit(COORD_W)] = second_is_max;
`endif
  end

`ifndef KEYPOINT_POLARITY_EN
  // Polarity inputs have no destination in this build
  logic unused_pol_c;
  assign unused_pol_c = first_is_max ^ second_is_max;
`endif

  kp_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (KP_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_in),
    .clear_i    (q_clear_c),
    .wr0_en_i   (q_wr0_c),
    .wr0_data_i (l1_word_c),
    .wr1_en_i   (q_wr1_c),
    .wr1_data_i (l2_word_c),
    .rd_en_i    (q_rd_c),
    .rd_data_o  (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .free_o     (q_free)
  );

  // Next state: enqueue/drop decisions, one dequeue per cycle, pass sequencing
  always_comb begin
    state_d    = state_q;
    kp_addr_d  = kp_addr_q;
    kp_data_d  = kp_data_q;
    kp_we_d    = 1'b0;
    kp_count_d = kp_count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    q_clear_c  = 1'b0;
    q_wr0_c    = 1'b0;
    q_wr1_c    = 1'b0;
    q_rd_c     = 1'b0;

    if (enable) begin
      // A new pass wipes everything pending, whatever state we were in
      state_d    = KP_COLLECT;
      kp_count_d = '0;
      overflow_d = 1'b0;
      q_clear_c  = 1'b1;
    end else begin
      if (state_q == KP_COLLECT) begin
        if (first_is_extremum) begin
          if (!q_full) q_wr0_c    = 1'b1;
          else         overflow_d = 1'b1;
        end
        if (second_is_extremum) begin
          if (q_free > FREE_W'(q_wr0_c)) q_wr1_c    = 1'b1;
          else                           overflow_d = 1'b1;
        end
      end

      if (!q_empty) begin
        q_rd_c = 1'b1;
        if (kp_count_q < CNT_W'(MAX_KEYPOINTS)) begin
          kp_we_d    = 1'b1;
          kp_addr_d  = kp_count_q[AW-1:0];
          kp_data_d  = q_head;
          kp_count_d = kp_count_q + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end

      case (state_q)
        KP_IDLE:    state_d = KP_IDLE;
        KP_COLLECT: if (done_checking) state_d = KP_DRAIN;
        KP_DRAIN: begin
          if (q_empty) begin
            state_d = KP_DONE;
            done_d  = 1'b1;
          end
        end
        KP_DONE:    state_d = KP_IDLE;
        default:    state_d = KP_IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= KP_IDLE;
      kp_addr_q  <= '0;
      kp_data_q  <= '0;
      kp_we_q    <= 1'b0;
      kp_count_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kp_addr_q  <= kp_addr_d;
      kp_data_q  <= kp_data_d;
      kp_we_q    <= kp_we_d;
      kp_count_q <= kp_count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign kp_addr  = kp_addr_q;
  assign kp_data  = kp_data_q;
  assign kp_we    = kp_we_q;
  assign kp_count = kp_count_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_keypoint_writer.sv
// Self-checking bench for keypoint_writer: directed scenarios plus randomized
// passes against a queue-based reference model. Two instances share stimulus,
// one with the default BRAM depth and one with depth 8.
module tb_keypoint_writer;
  import sift_pkg::*;

  localparam int unsigned CW = KP_COORD_W;
  localparam int unsigned KW = KP_WIDTH;
  localparam int QD    = 4;
  localparam int MAX_A = 1024;
  localparam int MAX_B = 8;
`ifdef KEYPOINT_POLARITY_EN
  localparam int POL_SCALE = 1 << KP_POL_BIT;
  localparam int S1_WORD   = 'h10C5;
  localparam int S5_WORD   = 'h2FC0;
`else
  localparam int POL_SCALE = 0;
  localparam int S1_WORD   = 'h0C5;
  localparam int S5_WORD   = 'h1FC0;
`endif

  logic          clk = 1'b0;
  logic          rst_in = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] x = '0;
  logic [CW-1:0] y = '0;
  logic          f1 = 1'b0, f2 = 1'b0, m1 = 1'b0, m2 = 1'b0, dc = 1'b0;

  logic [9:0]    a_addr;
  logic [KW-1:0] a_data;
  logic          a_we, a_ovf, a_done;
  logic [10:0]   a_count;
  logic [2:0]    b_addr;
  logic [KW-1:0] b_data;
  logic          b_we, b_ovf, b_done;
  logic [3:0]    b_count;

  keypoint_writer #(.DIMENSION(64), .MAX_KEYPOINTS(MAX_A), .QUEUE_DEPTH(QD)) dut_a (
    .clk(clk), .rst_in(rst_in), .enable(enable), .x(x), .y(y),
    .first_is_extremum(f1), .second_is_extremum(f2),
    .first_is_max(m1), .second_is_max(m2), .done_checking(dc),
    .kp_addr(a_addr), .kp_data(a_data), .kp_we(a_we),
    .kp_count(a_count), .overflow(a_ovf), .done(a_done));

  keypoint_writer #(.DIMENSION(64), .MAX_KEYPOINTS(MAX_B), .QUEUE_DEPTH(QD)) dut_b (
    .clk(clk), .rst_in(rst_in), .enable(enable), .x(x), .y(y),
    .first_is_extremum(f1), .second_is_extremum(f2),
    .first_is_max(m1), .second_is_max(m2), .done_checking(dc),
    .kp_addr(b_addr), .kp_data(b_data), .kp_we(b_we),
    .kp_count(b_count), .overflow(b_ovf), .done(b_done));

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t cap_a[$];
  wr_t cap_b[$];
  int  done_a = 0;
  int  done_b = 0;
  int  cyc = 0;

  // Record BRAM writes and done pulses mid-cycle
  always @(negedge clk) begin
    if (a_we) cap_a.push_back('{int'(a_addr), int'(a_data), cyc});
    if (b_we) cap_b.push_back('{int'(b_addr), int'(b_data), cyc});
    if (a_done) done_a <= done_a + 1;
    if (b_done) done_b <= done_b + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: pending keypoints, keypoints handed to the BRAM port, drop flag
  int mq[$];
  int mpops[$];
  bit mdrop = 1'b0;
  int mphase = 0;   // 0 idle, 1 collecting, 2 no more input accepted

  int base_a, base_b, dbase_a, dbase_b;

  function automatic int kp_word(input int layer, input int pol, input int xx, input int yy);
    return layer * (1 << KP_LAYER_BIT) + pol * POL_SCALE + xx * (1 << KP_X_LSB) + yy * (1 << KP_Y_LSB);
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Drive one cycle of checker outputs and advance the model by that cycle
  task automatic step(input bit e, input bit a1, input bit a2, input bit p1, input bit p2,
                      input int xx, input int yy, input bit d);
    int free;
    enable = e; f1 = a1; f2 = a2; m1 = p1; m2 = p2; dc = d;
    x = CW'(xx); y = CW'(yy);
    if (e) begin
      mq.delete(); mpops.delete(); mdrop = 1'b0; mphase = 1;
    end else begin
      free = QD - mq.size();
      if (mq.size() > 0) begin
        mpops.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (mphase == 1) begin
        if (a1) begin
          if (free > 0) begin mq.push_back(kp_word(0, int'(p1), xx, yy)); free--; end
          else mdrop = 1'b1;
        end
        if (a2) begin
          if (free > 0) begin mq.push_back(kp_word(1, int'(p2), xx, yy)); free--; end
          else mdrop = 1'b1;
        end
        if (d) mphase = 2;
      end
    end
    tick();
  endtask

  task automatic idle_step();
    step(1'b0, rb(), rb(), rb(), rb(), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
  endtask

  task automatic start_pass(input bit a1, input bit a2);
    step(1'b1, a1, a2, rb(), rb(), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
    base_a = cap_a.size(); base_b = cap_b.size();
    dbase_a = done_a; dbase_b = done_b;
  endtask

  task automatic check_inst(input string tag, input wr_t q[$], input int base, input int maxk,
                            input int cnt, input bit ovf, input int dcount);
    int n_exp, n_got;
    n_exp = (mpops.size() < maxk) ? mpops.size() : maxk;
    n_got = q.size() - base;
    check({tag, " writes"}, n_got, n_exp);
    for (int i = 0; i < n_exp && i < n_got; i++) begin
      check({tag, " addr"}, q[base + i].addr, i);
      check({tag, " data"}, q[base + i].data, mpops[i]);
    end
    check({tag, " kp_count"}, cnt, n_exp);
    check({tag, " overflow"}, ovf, mdrop || (mpops.size() > maxk));
    check({tag, " done pulses"}, dcount, 1);
  endtask

  // Let the pass drain (with ignored noise on the inputs) and compare both instances
  task automatic finish_pass(input string tag);
    int guard;
    guard = 0;
    while ((done_a == dbase_a) && guard < 60) begin
      idle_step();
      guard++;
    end
    check({tag, " done seen"}, guard < 60, 1);
    repeat (3) idle_step();
    check_inst({tag, " A"}, cap_a, base_a, MAX_A, int'(a_count), a_ovf, done_a - dbase_a);
    check_inst({tag, " B"}, cap_b, base_b, MAX_B, int'(b_count), b_ovf, done_b - dbase_b);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " kp_we"}, a_we, 0);
    check({tag, " kp_addr"}, a_addr, 0);
    check({tag, " kp_data"}, a_data, 0);
    check({tag, " kp_count"}, a_count, 0);
    check({tag, " overflow"}, a_ovf, 0);
    check({tag, " done"}, a_done, 0);
    check({tag, " B kp_count"}, b_count, 0);
  endtask

  initial begin
    int ce, len, held;

    // Reset state
    repeat (2) tick();
    check_zero("reset");
    rst_in = 1'b1;
    tick();

    // Single layer-1 maximum at (3,5)
    start_pass(1'b0, 1'b0);
    ce = cyc;
    step(0, 1, 0, 1, 0, 3, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    finish_pass("single");
    check("single word", (cap_a.size() > base_a) ? cap_a[base_a].data : -1, S1_WORD);
    // enqueued on the edge closing cycle ce, written on the following edge
    check("single latency", (cap_a.size() > base_a) ? cap_a[base_a].cyc - ce : -1, 2);
    check("single count", a_count, 1);

    // Both layers at (10,20) in the same cycle
    start_pass(1'b0, 1'b0);
    step(0, 1, 1, 0, 1, 10, 20, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    finish_pass("both");
    check("both back-to-back", (cap_a.size() > base_a + 1) ? cap_a[base_a + 1].cyc - cap_a[base_a].cyc : -1, 1);

    // Four cycles with both flags set, the first alongside enable
    start_pass(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, i + 1, 2 * i + 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    finish_pass("burst");
    check("burst count", a_count, 5);
    check("burst overflow", a_ovf, 1);

    // Ten isolated extrema; the depth-8 instance saturates
    start_pass(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, rb(), 0, i, 63 - i, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    finish_pass("saturate");
    check("saturate B count", b_count, 8);
    check("saturate B overflow", b_ovf, 1);
    check("saturate A count", a_count, 10);

    // Layer-2 minimum at (63,0), reported together with done_checking
    start_pass(1'b0, 1'b0);
    step(0, 0, 1, 1, 0, 63, 0, 1);
    finish_pass("corner");
    check("corner word", (cap_a.size() > base_a) ? cap_a[base_a].data : -1, S5_WORD);

    // Reset in the middle of collection, then a clean pass
    start_pass(1'b0, 1'b0);
    step(0, 1, 1, 0, 0, 4, 4, 0);
    step(0, 1, 0, 0, 0, 5, 5, 0);
    #2 rst_in = 1'b0;
    #1 check_zero("midreset");
    held = cap_a.size();
    mq.delete(); mpops.delete(); mdrop = 1'b0; mphase = 0;
    repeat (2) tick();
    check("midreset no writes", cap_a.size() - held, 0);
    rst_in = 1'b1;
    tick();
    start_pass(1'b0, 1'b0);
    step(0, 1, 0, 0, 0, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    finish_pass("after reset");

    // Re-enable while collecting abandons the old pass
    start_pass(1'b0, 1'b0);
    step(0, 1, 1, 1, 1, 1, 2, 0);
    step(0, 1, 1, 0, 0, 3, 4, 0);
    start_pass(1'b0, 1'b0);
    step(0, 0, 1, 0, 1, 33, 44, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    finish_pass("re-enable");

    // Randomized passes with noise while idle
    for (int p = 0; p < 14; p++) begin
      repeat (2) idle_step();
      start_pass(rb(), rb());
      len = int'($urandom_range(3, 30));
      for (int i = 0; i < len; i++)
        step(0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), rb(), rb(),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0);
      step(0, rb(), rb(), rb(), rb(), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1);
      finish_pass($sformatf("rand%0d", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
